// File: rtl/pending_encoder.sv
// -----------------------------------------------------------------------------
// pending_encoder
//
// Collects write requests into a 32-bit pending register and offers them one
// at a time, round-robin, over a Valid/Ready handshake. Requests are never
// dropped: a repeat request for an already-pending index is merged and
// flagged on Merge for one cycle.
//
// Ports
//   Clk      in   1   sole clock, rising edge
//   Rst      in   1   asynchronous reset, active low
//   ReqIn    in  32   request vector, bit i requests register i
//   Ready    in   1   consumer takes the offered index this cycle
//   Valid    out  1   an index is being offered on Awr
//   Awr      out  5   offered index, meaningful only while Valid=1
//   Pending  out 32   pending-request register
//   Count    out  6   number of set bits in Pending
//   Merge    out  1   one-cycle pulse: a request hit an already-pending bit
// -----------------------------------------------------------------------------
module pending_encoder (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] ReqIn,
    input  logic        Ready,
    output logic        Valid,
    output logic [4:0]  Awr,
    output logic [31:0] Pending,
    output logic [5:0]  Count,
    output logic        Merge
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // First set bit of vec, searching upward from index start and wrapping
    // 31 -> 0. The 5-bit index addition provides the wrap.
    function automatic logic [4:0] rr_select(input logic [31:0] vec,
                                             input logic [4:0]  start);
        logic [4:0] idx;
        logic       found;
        rr_select = '0;
        found     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            idx = start + 5'(i);
            if (!found && vec[idx]) begin
                rr_select = idx;
                found     = 1'b1;
            end
        end
    endfunction

    function automatic logic [5:0] popcount32(input logic [31:0] vec);
        popcount32 = '0;
        for (int i = 0; i < 32; i++) begin
            popcount32 = popcount32 + 6'(vec[i]);
        end
    endfunction

    state_t      state_q, state_d;
    logic [31:0] pend_q,  pend_d;
    logic [4:0]  ptr_q,   ptr_d;
    logic [4:0]  awr_q,   awr_d;
    logic [5:0]  count_q, count_d;
    logic        merge_q, merge_d;

    logic        accept;
    logic [31:0] awr_onehot;
    logic [31:0] clr;
    logic [31:0] remain;
    logic [4:0]  next_ptr;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned and a latch can never be inferred.
        state_d    = state_q;
        ptr_d      = ptr_q;
        awr_d      = awr_q;

        accept     = (state_q == OFFER) && Ready;
        awr_onehot = 32'h1 << awr_q;
        clr        = accept ? awr_onehot : '0;

        // OR-ing ReqIn after the clear makes a same-edge re-request win.
        pend_d     = (pend_q & ~clr) | ReqIn;
        merge_d    = |(ReqIn & pend_q & ~clr);
        // Count tracks the value Pending will hold, so both agree every cycle.
        count_d    = popcount32(pend_d);

        // Selection looks only at the registered vector: bits arriving on
        // this edge are offered no earlier than the next one.
        remain     = pend_q & ~awr_onehot;
        next_ptr   = awr_q + 5'd1;

        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    awr_d   = rr_select(pend_q, ptr_q);
                    state_d = OFFER;
                end
            end
            OFFER: begin
                // Without Ready the offer is frozen, even if a bit that
                // would win arbitration shows up meanwhile.
                if (Ready) begin
                    ptr_d = next_ptr;
                    if (remain != '0) begin
                        awr_d = rr_select(remain, next_ptr);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state is reset asynchronously so outputs clear the moment Rst
    // falls, without waiting for a clock edge; the release is assumed to be
    // synchronised by the surrounding system.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            ptr_q   <= '0;
            awr_q   <= '0;
            count_q <= '0;
            merge_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q <= state_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            awr_q   <= awr_d;
            count_q <= count_d;
            merge_q <= merge_d;
        end
    end

    assign Valid   = (state_q == OFFER);
    assign Awr     = awr_q;
    assign Pending = pend_q;
    assign Count   = count_q;
    assign Merge   = merge_q;

endmodule

// File: tb/tb_pending_encoder.sv
// -----------------------------------------------------------------------------
// tb_pending_encoder
//
// Cycle-level reference model feeds an expected-value queue as each stimulus
// cycle is driven; the entry is popped and compared one time unit after the
// clock edge. Directed checks with literal values cover the named scenarios.
// -----------------------------------------------------------------------------
module tb_pending_encoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_in;
    logic        ready;
    logic        valid;
    logic [4:0]  awr;
    logic [31:0] pending;
    logic [5:0]  count;
    logic        merge;

    pending_encoder dut (
        .Clk     (clk),
        .Rst     (rst_n),
        .ReqIn   (req_in),
        .Ready   (ready),
        .Valid   (valid),
        .Awr     (awr),
        .Pending (pending),
        .Count   (count),
        .Merge   (merge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  awr;
        logic [31:0] pend;
        logic [5:0]  count;
        logic        merge;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_p;
    int          m_ptr;
    logic        m_valid;
    int          m_awr;
    logic        m_merge;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_rr(input logic [31:0] v, input int start);
        for (int i = 0; i < 32; i++) begin
            if (v[(start + i) % 32]) return (start + i) % 32;
        end
        return 0;
    endfunction

    function automatic int ones(input logic [31:0] v);
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic model_reset();
        m_p     = '0;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_awr   = 0;
        m_merge = 1'b0;
    endtask

    // Advance the model by one edge with the given inputs, return expectations.
    task automatic model_step(input logic [31:0] r, input logic rd, output exp_t e);
        logic [31:0] sel_bit;
        logic [31:0] taken;
        logic [31:0] left;
        logic [31:0] old_p;
        old_p   = m_p;
        sel_bit = 32'h0;
        sel_bit[m_awr] = 1'b1;
        taken   = (m_valid && rd) ? sel_bit : 32'h0;
        m_merge = (r & old_p & ~taken) != 0;
        m_p     = (old_p & ~taken) | r;
        if (!m_valid) begin
            if (old_p != 0) begin
                m_awr   = model_rr(old_p, m_ptr);
                m_valid = 1'b1;
            end
        end else if (rd) begin
            m_ptr = (m_awr + 1) % 32;
            left  = old_p & ~sel_bit;
            if (left != 0) m_awr = model_rr(left, m_ptr);
            else           m_valid = 1'b0;
        end
        e.valid = m_valid;
        e.awr   = 5'(m_awr);
        e.pend  = m_p;
        e.count = 6'(ones(m_p));
        e.merge = m_merge;
    endtask

    // Drive one cycle of stimulus, then compare against the scoreboard.
    task automatic step(input logic [31:0] r, input logic rd);
        exp_t e;
        exp_t got;
        req_in = r;
        ready  = rd;
        model_step(r, rd, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("sb_valid",   32'(valid),   32'(got.valid));
        check("sb_pending", pending,      got.pend);
        check("sb_count",   32'(count),   32'(got.count));
        check("sb_merge",   32'(merge),   32'(got.merge));
        if (got.valid) check("sb_awr", 32'(awr), 32'(got.awr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        req_in = '0;
        ready  = 1'b0;
        model_reset();
        #22;
        check("rst_valid",   32'(valid),   32'd0);
        check("rst_awr",     32'(awr),     32'd0);
        check("rst_pending", pending,      32'd0);
        check("rst_count",   32'(count),   32'd0);
        check("rst_merge",   32'(merge),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: visible after k, offered after k+1, then accepted.
        step(32'h0000_0008, 1'b1);
        check("single_idle_k", 32'(valid), 32'd0);
        step(32'h0, 1'b1);
        check("single_valid", 32'(valid), 32'd1);
        check("single_awr",   32'(awr),   32'd3);
        step(32'h0, 1'b1);
        check("single_done_valid", 32'(valid), 32'd0);
        check("single_done_pend",  pending,    32'd0);

        // Ready without an offer has no effect.
        step(32'h0, 1'b1);

        // Round robin with wrap: accept 29 so the pointer sits at 30.
        step(32'h2000_0000, 1'b1);
        step(32'h0, 1'b1);
        check("rr_awr29", 32'(awr), 32'd29);
        step(32'h0, 1'b1);
        step(32'h8000_0021, 1'b1);
        check("rr_count3_pre", 32'(count), 32'd3);
        step(32'h0, 1'b1);
        check("rr_awr31",  32'(awr),   32'd31);
        check("rr_count3", 32'(count), 32'd3);
        step(32'h0, 1'b1);
        check("rr_awr0",   32'(awr),   32'd0);
        check("rr_count2", 32'(count), 32'd2);
        step(32'h0, 1'b1);
        check("rr_awr5",   32'(awr),   32'd5);
        check("rr_count1", 32'(count), 32'd1);
        step(32'h0, 1'b1);
        check("rr_count0", 32'(count), 32'd0);
        check("rr_idle",   32'(valid), 32'd0);

        // Stall: offer 4, hold for five cycles while bit 1 arrives.
        step(32'h0000_0010, 1'b0);
        step(32'h0, 1'b0);
        check("stall_awr4", 32'(awr), 32'd4);
        step(32'h0000_0002, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(32'h0, 1'b0);
            check("stall_hold_awr",   32'(awr),   32'd4);
            check("stall_hold_valid", 32'(valid), 32'd1);
        end
        step(32'h0, 1'b1);
        check("stall_next_awr1", 32'(awr), 32'd1);
        step(32'h0, 1'b1);

        // Set wins over clear; a repeat while pending pulses Merge.
        step(32'h0000_0080, 1'b0);
        step(32'h0, 1'b0);
        check("setwin_awr7", 32'(awr), 32'd7);
        step(32'h0000_0080, 1'b1);
        check("setwin_pend",  pending,    32'h0000_0080);
        check("setwin_merge", 32'(merge), 32'd0);
        step(32'h0, 1'b0);
        check("setwin_reoffer", 32'(awr), 32'd7);
        step(32'h0000_0080, 1'b0);
        check("merge_pulse", 32'(merge), 32'd1);
        step(32'h0, 1'b0);
        check("merge_clear", 32'(merge), 32'd0);
        step(32'h0, 1'b1);

        // Asynchronous reset mid-offer with ten requests pending.
        step(32'h0000_03FF, 1'b0);
        step(32'h0, 1'b0);
        check("pre_rst_count", 32'(count), 32'd10);
        check("pre_rst_valid", 32'(valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid",   32'(valid), 32'd0);
        check("async_rst_count",   32'(count), 32'd0);
        check("async_rst_pending", pending,    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Full vector: 32 indices accepted in 32 consecutive cycles.
        step(32'hFFFF_FFFF, 1'b1);
        check("full_count", 32'(count), 32'd32);
        step(32'h0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            check("full_valid", 32'(valid), 32'd1);
            check("full_awr",   32'(awr),   32'(i));
            step(32'h0, 1'b1);
        end
        check("full_done_valid", 32'(valid), 32'd0);
        check("full_done_count", 32'(count), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 200; i++) begin
            logic [31:0] r;
            r = ($urandom_range(0, 3) == 0) ? $urandom() & $urandom() : 32'h0;
            step(r, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40; i++) step(32'h0, 1'b1);
        check("drain_valid", 32'(valid), 32'd0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pending_encoder.md
PENDING_ENCODER -- requirements
Module: pending_encoder

Interface
REQ-001 The module SHALL have parameter-free ports in this order: Clk input 1 (sole clock, rising edge); Rst input 1 (reset, asynchronous, active-low).
REQ-002 ReqIn  input  32  one-hot-or-multi-hot write request vector; bit i requests register i.
REQ-003 Ready  input  1  consumer accepts the offered index this cycle.
REQ-004 Valid  output 1  an index is being offered on Awr.
REQ-005 Awr  output 5  offered register index (0..31), meaningful only while Valid=1.
REQ-006 Pending  output 32  current pending-request register P.
REQ-007 Count  output 6  number of set bits in P (0..32).
REQ-008 Merge  output 1  one-cycle pulse: a ReqIn bit arrived while already pending.

Function
REQ-009 P SHALL update each rising edge as P_next = (P & ~clr) | ReqIn, where clr = onehot(Awr) when Valid&Ready, else 0.
REQ-010 A bit set in ReqIn on the same edge it is cleared by acceptance SHALL remain set (set wins).
REQ-011 Merge SHALL be registered as |(ReqIn & P & ~clr); no request is ever lost and no overflow exists.
REQ-012 Count SHALL be the registered popcount of P_next, i.e. consistent with Pending in the same cycle.
REQ-013 The FSM SHALL have two states: IDLE (Valid=0) and OFFER (Valid=1).
REQ-014 IDLE: if P != 0 at an edge, latch Awr = rr_select(P, Ptr) and go to OFFER; otherwise stay IDLE.
REQ-015 rr_select(V, Ptr) SHALL return the first set bit of V searching upward from index Ptr, wrapping 31 -> 0.
REQ-016 OFFER with Ready=0: Awr and Valid SHALL hold unchanged, even if higher-priority bits arrive.
REQ-017 OFFER with Ready=1: Ptr <= (Awr+1) mod 32; let R = P & ~onehot(Awr); if R != 0 latch Awr = rr_select(R, (Awr+1) mod 32) and stay OFFER, else go to IDLE.
REQ-018 ReqIn bits arriving on the acceptance edge SHALL NOT be considered by that edge's selection; they are offered no earlier than the following edge (one-cycle sampling latency).
REQ-019 Latency: ReqIn sampled at edge k into an empty, IDLE block SHALL give Valid=1 with that index after edge k+1.
REQ-020 Back-to-back throughput: with Ready held 1 and N bits pending, N indices SHALL be accepted in N consecutive cycles.
REQ-021 Awr SHALL always correspond to a bit set in Pending while Valid=1.
REQ-022 Ready while Valid=0 SHALL have no effect.

Reset
REQ-023 Rst=0 SHALL asynchronously force P=0, Ptr=0, state=IDLE, Valid=0, Awr=0, Count=0, Merge=0, independent of Clk.
REQ-024 Reset asserted mid-offer SHALL discard all pending requests; after release, the first edge samples ReqIn normally.
REQ-025 Reset deassertion SHALL be treated as synchronous to Clk by the surrounding system; no internal synchronizer.

Verification
REQ-026 Single: ReqIn=32'h0000_0008 for one cycle, Ready=1 -> Valid=1 with Awr=3 after edge k+1, accepted; Pending returns to 0, Valid=0 next cycle.
REQ-027 Round robin/wrap: Ptr=30 (after accepting 29), P = bits {0,5,31}, Ready=1 -> Awr sequence 31, 0, 5; Count 3,2,1,0.
REQ-028 Stall: offer Awr=4, Ready=0 for 5 cycles, ReqIn bit 1 set meanwhile -> Awr holds 4, Valid holds 1; on Ready=1 next offer Awr=1 (wrap search from 5).
REQ-029 Set-wins: offering Awr=7, Ready=1 and ReqIn bit 7 on the same edge -> bit 7 remains in Pending, re-offered later; Merge=0; ReqIn bit 7 again while pending -> Merge pulses 1 for one cycle.
REQ-030 Full: ReqIn=32'hFFFF_FFFF one cycle, Ready=1 -> Count=32, then indices 0..31 accepted in 32 consecutive cycles, Valid drops after index 31.
REQ-031 Reset mid-operation: Rst=0 between clock edges with Count=10 -> Valid, Count, Pending become 0 immediately, before the next edge.
